fir_rr_scheduler: RTL
=====================

Name: fir_rr_scheduler

Overview:
- Time-multiplexes one shared decimating FIR engine between two audio channels (e.g. L+R and L−R) using round-robin scheduling.
- The engine keeps a separate tap history per channel, selected by fir_ch.
- The scheduler gives each granted channel exactly DECIMATION input samples, then routes the single resulting output to that channel's output FIFO.
- Sits between the channel input FIFOs and the per-channel output FIFOs.

Parameters:
DATA_SIZE, 32, sample width on all data paths
DECIMATION, 8, input samples consumed per FIR output; must match the engine

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ch_en  in  2  per-channel enable; bit n=0 excludes channel n from arbitration
in0_dout  in  DATA_SIZE  channel 0 input FIFO head
in0_empty  in  1  channel 0 input FIFO empty
in0_rd_en  out  1  channel 0 input FIFO pop
in1_dout  in  DATA_SIZE  channel 1 input FIFO head
in1_empty  in  1  channel 1 input FIFO empty
in1_rd_en  out  1  channel 1 input FIFO pop
fir_x_in  out  DATA_SIZE  sample presented to the engine
fir_x_empty  out  1  virtual-FIFO empty seen by the engine
fir_x_rd_en  in  1  engine pop
fir_ch  out  1  channel context currently selected in the engine
fir_y_out  in  DATA_SIZE  engine result
fir_y_wr_en  in  1  engine result valid
fir_y_full  out  1  virtual-FIFO full seen by the engine
out0_din  out  DATA_SIZE  channel 0 output FIFO data
out0_wr_en  out  1  channel 0 output FIFO push
out0_full  in  1  channel 0 output FIFO full
out1_din  out  DATA_SIZE  channel 1 output FIFO data
out1_wr_en  out  1  channel 1 output FIFO push
out1_full  in  1  channel 1 output FIFO full
err  out  1  sticky protocol error flag

Behaviour:
- Registered state: state {IDLE, FEED, WAIT_OUT}, fir_ch, cnt (log2 DECIMATION bits), last_grant, err.
- Reset values: state=IDLE, fir_ch=0, cnt=0, last_grant=1 (channel 0 wins the first arbitration), err=0.
- Reset also forces every combinational output to its idle value. Reset mid-burst abandons the burst; the engine's context is reset by the same reset.
- Channel n is eligible when ch_en[n]=1, in_n_empty=0 and out_n_full=0.
- IDLE:
  - Priority goes to channel (last_grant+1) mod 2, then the other channel.
  - If any channel is eligible: fir_ch<=winner, cnt<=0, next state FEED. Grant takes 1 cycle.
  - If none is eligible, stay in IDLE.
- FEED (combinational pass-through, zero added latency):
  - fir_x_in = dout of channel fir_ch.
  - fir_x_empty = empty of channel fir_ch.
  - rd_en of channel fir_ch = fir_x_rd_en; the other channel's rd_en = 0.
  - Each cycle with fir_x_rd_en=1 and fir_x_empty=0 increments cnt.
  - The read with cnt==DECIMATION−1 sets cnt<=0 and moves to WAIT_OUT.
  - An empty source stalls the burst indefinitely. The grant is never revoked mid-burst, and ch_en changes during a burst are ignored.
- WAIT_OUT:
  - fir_x_empty=1.
  - fir_y_full = full of channel fir_ch.
  - out_n_din = fir_y_out and out_n_wr_en = fir_y_wr_en for n=fir_ch; the other channel's wr_en = 0.
  - When fir_y_wr_en=1: last_grant<=fir_ch, next state IDLE. Re-arbitration happens the following cycle.
  - If the output FIFO is full, the engine holds its result. WAIT_OUT persists until the write occurs.
- Outside FEED: fir_x_empty=1 and all in_rd_en=0.
- Outside WAIT_OUT: fir_y_full=1 and all out_wr_en=0.
- fir_x_in and out_n_din are 0 when not routed.
- Protocol errors (set err=1 until reset; the event is otherwise ignored and not counted):
  - fir_y_wr_en=1 outside WAIT_OUT.
  - fir_x_rd_en=1 while fir_x_empty=1.
- Sustained throughput: one output per DECIMATION reads + 2 scheduler cycles + engine compute time, alternating channels when both are eligible.

Test Plan:
- Only channel 0 enabled, 16 samples 1..16 in in0 → 16 pops from in0 only, fir_ch=0 throughout, 2 writes to out0, out1_wr_en never asserted.
- Both channels enabled, each holding 8 samples → first burst on ch0 then ch1, exactly 8 pops each, out0 and out1 each receive 1 result equal to the engine output for that context.
- Both channels continuously non-empty for 6 bursts → grant sequence 0,1,0,1,0,1; in FEED, in_rd_en of the ungranted channel is always 0.
- out0_full=1 when the engine asserts its result on a ch0 burst → fir_y_full=1, no out0 push, state stays WAIT_OUT; release full after 5 cycles → exactly one push to out0, then IDLE.
- in1 runs empty after 3 of 8 samples in a ch1 burst → fir_x_empty=1, cnt holds at 3, no switch to ch0; refill → burst completes after 5 more pops.
- fir_y_wr_en pulsed in IDLE → err=1, no output push; reset asserted mid-FEED → all outputs idle immediately, next grant goes to ch0, err=0.

Source files
------------

// File: rtl/fir_rr_scheduler.sv
// Round-robin scheduler that time-multiplexes one decimating FIR engine
// between two channels. A granted channel feeds exactly DECIMATION samples
// to the engine, then the single engine result is routed to that channel's
// output FIFO before the next arbitration.
module fir_rr_scheduler #(
    parameter int DATA_SIZE  = 32,
    parameter int DECIMATION = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           ch_en,
    input  logic [DATA_SIZE-1:0] in0_dout,
    input  logic                 in0_empty,
    output logic                 in0_rd_en,
    input  logic [DATA_SIZE-1:0] in1_dout,
    input  logic                 in1_empty,
    output logic                 in1_rd_en,
    output logic [DATA_SIZE-1:0] fir_x_in,
    output logic                 fir_x_empty,
    input  logic                 fir_x_rd_en,
    output logic                 fir_ch,
    input  logic [DATA_SIZE-1:0] fir_y_out,
    input  logic                 fir_y_wr_en,
    output logic                 fir_y_full,
    output logic [DATA_SIZE-1:0] out0_din,
    output logic                 out0_wr_en,
    input  logic                 out0_full,
    output logic [DATA_SIZE-1:0] out1_din,
    output logic                 out1_wr_en,
    input  logic                 out1_full,
    output logic                 err
);

    localparam int CNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATION - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FEED     = 2'd1,
        WAIT_OUT = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_fir_ch;
    logic             r_last_grant;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic       w_feed;
    logic       w_wait;
    logic       w_pop;
    logic [1:0] w_elig;
    logic       w_any;
    logic       w_pref;
    logic       w_winner;
    logic       w_proto_err;

    // Routing windows are gated by reset so every routed output idles at once.
    assign w_feed = (r_state == FEED) && !reset;
    assign w_wait = (r_state == WAIT_OUT) && !reset;

    assign w_elig[0] = ch_en[0] & ~in0_empty & ~out0_full;
    assign w_elig[1] = ch_en[1] & ~in1_empty & ~out1_full;
    assign w_any     = |w_elig;
    // The channel not served last time gets first chance at the grant.
    assign w_pref    = ~r_last_grant;
    assign w_winner  = w_elig[w_pref] ? w_pref : ~w_pref;

    assign w_pop       = w_feed && fir_x_rd_en && !fir_x_empty;
    assign w_proto_err = (fir_y_wr_en && !w_wait) || (fir_x_rd_en && fir_x_empty);

    assign fir_ch = r_fir_ch;
    assign err    = r_err;

    // Steer the engine's virtual input/output FIFOs to the granted channel.
    always_comb begin
        fir_x_in    = '0;
        fir_x_empty = 1'b1;
        in0_rd_en   = 1'b0;
        in1_rd_en   = 1'b0;
        fir_y_full  = 1'b1;
        out0_din    = '0;
        out0_wr_en  = 1'b0;
        out1_din    = '0;
        out1_wr_en  = 1'b0;
        if (w_feed) begin
            if (r_fir_ch) begin
                fir_x_in    = in1_dout;
                fir_x_empty = in1_empty;
                in1_rd_en   = fir_x_rd_en;
            end else begin
                fir_x_in    = in0_dout;
                fir_x_empty = in0_empty;
                in0_rd_en   = fir_x_rd_en;
            end
        end
        if (w_wait) begin
            if (r_fir_ch) begin
                fir_y_full = out1_full;
                out1_din   = fir_y_out;
                out1_wr_en = fir_y_wr_en;
            end else begin
                fir_y_full = out0_full;
                out0_din   = fir_y_out;
                out0_wr_en = fir_y_wr_en;
            end
        end
    end

    // Scheduler FSM: arbitrate, count a full decimation burst, await the result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_fir_ch     <= 1'b0;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_err        <= 1'b0;
        end else begin
            if (w_proto_err) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_fir_ch <= w_winner;
                        r_cnt    <= '0;
                        r_state  <= FEED;
                    end
                end
                FEED: begin
                    if (w_pop) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= WAIT_OUT;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                WAIT_OUT: begin
                    if (fir_y_wr_en) begin
                        r_last_grant <= r_fir_ch;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
